vid_addr_cnt: RTL and testbench



---
 rtl/vid_addr_cnt.sv | 90 +++++++++
 tb/tb_vid_addr_cnt.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/vid_addr_cnt.sv
// Video fetch word-address counter: frame reload, per-word advance, line-end add, CPU byte-lane access.
// Optional VIDCNT_SNAPSHOT_EN: top-lane read latches a snapshot so multi-byte reads are tear-free.
module vid_addr_cnt #(
  parameter int WW = 21,
  parameter int LW = 8,
  parameter int NL = (WW + 8) / 8
) (
  input  logic          clk32,
  input  logic          porb,
  input  logic          cnt_en,
  input  logic          line_end,
  input  logic          frame_start,
  input  logic [WW-1:0] base,
  input  logic [LW-1:0] loff,
  input  logic          wr_en,
  input  logic [NL-1:0] wr_sel,
  input  logic [7:0]    wr_data,
  input  logic          rd_en,
  input  logic [NL-1:0] rd_sel,
  output logic [7:0]    rd_data,
  output logic [WW-1:0] vid,
  output logic          wrap
);
  localparam int BW = NL * 8;

  logic [WW-1:0]        cnt;
  logic [NL-1:0][7:0]   cur_b, src_b, wr_b;
  logic [BW-1:0]        wr_flat;
  logic [WW:0]          sum;
  logic [7:0]           rd_nxt;
  logic                 unused_ok;

  // Byte-address view of the word counter; bit 0 and bits above WW read as zero.
  assign cur_b = BW'({cnt, 1'b0});

  for (genvar k = 0; k < NL; k++) begin : g_lane
    assign wr_b[k] = wr_sel[k] ? wr_data : cur_b[k];
  end
  assign wr_flat = wr_b;

  // One extra bit catches the carry out of the top word-address bit.
  assign sum = {1'b0, cnt} + (WW+1)'({LW{line_end}} & loff) + (WW+1)'(cnt_en);

`ifdef VIDCNT_SNAPSHOT_EN
  logic [WW-1:0]      snap;
  logic [NL-1:0][7:0] snap_b;
  assign snap_b = BW'({snap, 1'b0});
  always_comb begin
    src_b         = snap_b;
    src_b[NL-1]   = cur_b[NL-1];
  end
  assign unused_ok = ^{wr_flat[0], wr_flat[BW-1:WW], snap_b[NL-1]};
`else
  assign src_b     = cur_b;
  assign unused_ok = ^{wr_flat[0], wr_flat[BW-1:WW]};
`endif

  always_comb begin
    rd_nxt = '0;
    for (int k = 0; k < NL; k++)
      if (rd_sel[k]) rd_nxt = rd_nxt | src_b[k];
  end

  always_ff @(posedge clk32 or negedge porb) begin
    if (!porb) begin
      cnt     <= '0;
      wrap    <= 1'b0;
      rd_data <= '0;
`ifdef VIDCNT_SNAPSHOT_EN
      snap    <= '0;
`endif
    end else begin
      wrap <= 1'b0;
      if (frame_start)
        cnt <= base;
      else if (wr_en)
        cnt <= wr_flat[WW:1];
      else begin
        cnt  <= sum[WW-1:0];
        wrap <= sum[WW];
      end
      if (rd_en) rd_data <= rd_nxt;
`ifdef VIDCNT_SNAPSHOT_EN
      if (rd_en && rd_sel[NL-1]) snap <= cnt;
`endif
    end
  end

  assign vid = cnt;
endmodule

// File: tb/tb_vid_addr_cnt.sv
// Bench for vid_addr_cnt: directed vector table, async reset sequence, random run against an arithmetic model.
module tb_vid_addr_cnt;
  localparam int WW = 21;
  localparam int LW = 8;
  localparam int NL = (WW + 8) / 8;
  localparam longint MOD = 64'd1 << WW;
`ifdef VIDCNT_SNAPSHOT_EN
  localparam logic [7:0] EXP_L0 = 8'h5E;
`else
  localparam logic [7:0] EXP_L0 = 8'h68;
`endif

  logic          clk32 = 1'b0, porb = 1'b0;
  logic          cnt_en = 0, line_end = 0, frame_start = 0, wr_en = 0, rd_en = 0;
  logic [WW-1:0] base = '0;
  logic [LW-1:0] loff = '0;
  logic [NL-1:0] wr_sel = '0, rd_sel = '0;
  logic [7:0]    wr_data = '0;
  logic [7:0]    rd_data;
  logic [WW-1:0] vid;
  logic          wrap;

  vid_addr_cnt #(.WW(WW), .LW(LW), .NL(NL)) dut (
    .clk32(clk32), .porb(porb), .cnt_en(cnt_en), .line_end(line_end),
    .frame_start(frame_start), .base(base), .loff(loff), .wr_en(wr_en),
    .wr_sel(wr_sel), .wr_data(wr_data), .rd_en(rd_en), .rd_sel(rd_sel),
    .rd_data(rd_data), .vid(vid), .wrap(wrap));

  always #5 clk32 = ~clk32;

  int npass = 0, ntot = 0;
  longint m_cnt = 0, m_snap = 0;
  longint m_wrap = 0, m_rd = 0;

  typedef struct {
    int            n;
    bit            fs, le, ce, we, re;
    logic [NL-1:0] wsel, rsel;
    logic [7:0]    wd;
    logic [WW-1:0] bs;
    logic [LW-1:0] lo;
    logic [WW-1:0] evid;
    bit            ewrap, crd;
    logic [7:0]    erd;
  } vec_t;
  vec_t tv[$];

  task automatic chk(input string nm, input longint act, input longint exp);
    ntot++;
    if (act == exp) npass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  // Reference: the counter as an integer word address, CPU lanes as byte slices of 2*cnt.
  task automatic model_step();
    longint ba, src, s;
    int k;
    if (rd_en) begin
      k = 0;
      for (int i = 0; i < NL; i++) if (rd_sel[i]) k = i;
`ifdef VIDCNT_SNAPSHOT_EN
      if (k == NL-1) begin m_snap = m_cnt; src = m_cnt; end
      else src = m_snap;
`else
      src = m_cnt;
`endif
      m_rd = ((src * 2) >> (8 * k)) & 255;
    end
    m_wrap = 0;
    if (frame_start) m_cnt = longint'(base);
    else if (wr_en) begin
      ba = m_cnt * 2;
      for (int i = 0; i < NL; i++)
        if (wr_sel[i]) ba = (ba & ~(longint'(255) << (8 * i))) | (longint'(wr_data) << (8 * i));
      m_cnt = (ba / 2) % MOD;
    end else begin
      s = m_cnt + (line_end ? longint'(loff) : 0) + (cnt_en ? 1 : 0);
      m_wrap = (s >= MOD) ? 1 : 0;
      m_cnt = s % MOD;
    end
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk32); #1;
  endtask

  task automatic idle();
    frame_start = 0; line_end = 0; cnt_en = 0; wr_en = 0; rd_en = 0;
    wr_sel = '0; rd_sel = '0;
  endtask

  initial begin
    tv.push_back('{1, 1,0,0,0,0, 3'b000,3'b000, 8'h00, 21'h07C000, 8'h00, 21'h07C000, 0,0,8'h00});
    tv.push_back('{16,0,0,1,0,0, 3'b000,3'b000, 8'h00, 21'h000000, 8'h00, 21'h07C010, 0,0,8'h00});
    tv.push_back('{1, 1,0,0,0,0, 3'b000,3'b000, 8'h00, 21'h000100, 8'h00, 21'h000100, 0,0,8'h00});
    tv.push_back('{1, 0,1,1,0,0, 3'b000,3'b000, 8'h00, 21'h000000, 8'h50, 21'h000151, 0,0,8'h00});
    tv.push_back('{1, 0,1,0,0,0, 3'b000,3'b000, 8'h00, 21'h000000, 8'h00, 21'h000151, 0,0,8'h00});
    tv.push_back('{1, 1,0,1,1,0, 3'b001,3'b000, 8'hFF, 21'h000100, 8'h00, 21'h000100, 0,0,8'h00});
    tv.push_back('{1, 0,0,1,1,0, 3'b001,3'b000, 8'hFF, 21'h000000, 8'h00, 21'h00017F, 0,0,8'h00});
    tv.push_back('{1, 0,0,0,0,1, 3'b000,3'b001, 8'h00, 21'h000000, 8'h00, 21'h00017F, 0,1,8'hFE});
    tv.push_back('{1, 1,0,0,0,0, 3'b000,3'b000, 8'h00, 21'h1FFFFF, 8'h00, 21'h1FFFFF, 0,0,8'h00});
    tv.push_back('{1, 0,0,1,0,0, 3'b000,3'b000, 8'h00, 21'h000000, 8'h00, 21'h000000, 1,0,8'h00});
    tv.push_back('{1, 0,0,0,0,0, 3'b000,3'b000, 8'h00, 21'h000000, 8'h00, 21'h000000, 0,0,8'h00});
    tv.push_back('{1, 1,0,0,0,0, 3'b000,3'b000, 8'h00, 21'h1FFF80, 8'h00, 21'h1FFF80, 0,0,8'h00});
    tv.push_back('{1, 0,1,0,0,0, 3'b000,3'b000, 8'h00, 21'h000000, 8'h80, 21'h000000, 1,0,8'h00});
    tv.push_back('{1, 0,0,0,1,0, 3'b100,3'b000, 8'hFF, 21'h000000, 8'h00, 21'h1F8000, 0,0,8'h00});
    tv.push_back('{1, 0,0,0,0,1, 3'b000,3'b100, 8'h00, 21'h000000, 8'h00, 21'h1F8000, 0,1,8'h3F});
    tv.push_back('{1, 1,0,0,0,0, 3'b000,3'b000, 8'h00, 21'h091A2F, 8'h00, 21'h091A2F, 0,0,8'h00});
    tv.push_back('{1, 0,0,0,0,1, 3'b000,3'b100, 8'h00, 21'h000000, 8'h00, 21'h091A2F, 0,1,8'h12});
    tv.push_back('{1, 0,0,0,0,1, 3'b000,3'b010, 8'h00, 21'h000000, 8'h00, 21'h091A2F, 0,1,8'h34});
    tv.push_back('{1, 0,0,0,0,1, 3'b000,3'b001, 8'h00, 21'h000000, 8'h00, 21'h091A2F, 0,1,8'h5E});
    tv.push_back('{1, 0,0,0,0,1, 3'b000,3'b100, 8'h00, 21'h000000, 8'h00, 21'h091A2F, 0,1,8'h12});
    tv.push_back('{5, 0,0,1,0,0, 3'b000,3'b000, 8'h00, 21'h000000, 8'h00, 21'h091A34, 0,0,8'h00});
    tv.push_back('{1, 0,0,0,0,1, 3'b000,3'b010, 8'h00, 21'h000000, 8'h00, 21'h091A34, 0,1,8'h34});
    tv.push_back('{1, 0,0,0,0,1, 3'b000,3'b001, 8'h00, 21'h000000, 8'h00, 21'h091A34, 0,1,EXP_L0});

    #12;
    chk("rst_vid", vid, 0);
    chk("rst_wrap", wrap, 0);
    chk("rst_rd", rd_data, 0);
    @(negedge clk32); porb = 1;

    foreach (tv[i]) begin
      frame_start = tv[i].fs; line_end = tv[i].le; cnt_en = tv[i].ce;
      wr_en = tv[i].we; rd_en = tv[i].re; wr_sel = tv[i].wsel; rd_sel = tv[i].rsel;
      wr_data = tv[i].wd; base = tv[i].bs; loff = tv[i].lo;
      repeat (tv[i].n) cyc();
      chk($sformatf("vec%0d_vid", i), vid, tv[i].evid);
      chk($sformatf("vec%0d_wrap", i), wrap, tv[i].ewrap);
      if (tv[i].crd) chk($sformatf("vec%0d_rd", i), rd_data, tv[i].erd);
    end
    idle();

    // Asynchronous reset between edges during a count run, then the first strobe after release.
    cnt_en = 1;
    repeat (3) cyc();
    #2 porb = 0;
    #1;
    chk("arst_vid", vid, 0);
    chk("arst_wrap", wrap, 0);
    chk("arst_rd", rd_data, 0);
    m_cnt = 0; m_snap = 0; m_wrap = 0; m_rd = 0;
    @(negedge clk32); porb = 1;
    cyc();
    chk("arst_first_ce", vid, 1);
    idle();

    for (int c = 0; c < 400; c++) begin
      frame_start = ($urandom_range(0, 15) == 0);
      wr_en       = ($urandom_range(0, 7) == 0);
      line_end    = ($urandom_range(0, 3) == 0);
      cnt_en      = $urandom_range(0, 1) == 1;
      rd_en       = ($urandom_range(0, 3) == 0);
      wr_sel      = NL'($urandom);
      rd_sel      = NL'(1) << $urandom_range(0, NL-1);
      wr_data     = 8'($urandom);
      base        = ($urandom_range(0, 3) == 0) ? WW'(MOD - 1 - $urandom_range(0, 8)) : WW'($urandom);
      loff        = LW'($urandom);
      cyc();
      chk("rnd_vid", vid, m_cnt);
      chk("rnd_wrap", wrap, m_wrap);
      chk("rnd_rd", rd_data, m_rd);
    end
    idle();

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
